// File: rtl/score_keeper.sv
// Baseball scoreboard: applies one batting event per accepted handshake, then
// locks out new events for LOCKOUT cycles. All outputs are registered.
module score_keeper #(
  parameter int SCORE_W = 5,
  parameter int INN_W   = 4,
  parameter int INNINGS = 9,
  parameter int LOCKOUT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               event_valid,
  input  logic [2:0]         event_code,
  output logic               event_ready,
  output logic [2:0]         bases,
  output logic [2:0]         runs,
  output logic               runs_valid,
  output logic [SCORE_W-1:0] score_away,
  output logic [SCORE_W-1:0] score_home,
  output logic [1:0]         outs,
  output logic [INN_W-1:0]   inning,
  output logic               half,
  output logic               game_over,
  output logic               sat
);

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  localparam int SUM_W = SCORE_W + 3;
  localparam logic [SCORE_W-1:0] MAX_SCORE = {SCORE_W{1'b1}};
  localparam logic [INN_W-1:0]   MAX_INN   = {INN_W{1'b1}};

  state_t      state;
  logic [2:0]  hold_cnt;

  logic               code_ok, is_out, third, late, clip;
  logic [2:0]         mv_bases, mv_runs, pop;
  logic [SCORE_W-1:0] bat_score, new_bat, n_away, n_home;
  logic [SUM_W-1:0]   sum;
  logic               n_over;

  assign event_ready = (state == IDLE) && !game_over;

  always_comb begin
    pop      = 3'(bases[0]) + 3'(bases[1]) + 3'(bases[2]);
    mv_bases = bases;
    mv_runs  = 3'd0;
    case (event_code)
      3'd1: begin mv_bases = {bases[1], bases[0], 1'b1}; mv_runs = 3'(bases[2]); end
      3'd2: begin mv_bases = {bases[0], 2'b10}; mv_runs = 3'(bases[2]) + 3'(bases[1]); end
      3'd3: begin mv_bases = 3'b100; mv_runs = pop; end
      3'd4: begin mv_bases = 3'b000; mv_runs = pop + 3'd1; end
      // walk: only a runner with every base behind him occupied is forced
      3'd5: begin
        mv_bases = {bases[2] | (&bases[1:0]), |bases[1:0], 1'b1};
        mv_runs  = 3'(&bases);
      end
      default: ;
    endcase

    code_ok   = (event_code != 3'd0) && (event_code != 3'd7);
    is_out    = (event_code == 3'd6);
    third     = is_out && (outs == 2'd2);
    late      = (inning >= INN_W'(INNINGS));

    bat_score = half ? score_home : score_away;
    sum       = SUM_W'(bat_score) + SUM_W'(mv_runs);
    clip      = (sum > SUM_W'(MAX_SCORE));
    new_bat   = clip ? MAX_SCORE : sum[SCORE_W-1:0];
    n_away    = half ? score_away : new_bat;
    n_home    = half ? new_bat : score_home;

    n_over = (third && late && (half ? (n_home != n_away) : (n_home > n_away))) ||
             (half && late && (n_home > n_away));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= 3'd0;
      bases      <= 3'b000;
      runs       <= 3'd0;
      runs_valid <= 1'b0;
      score_away <= '0;
      score_home <= '0;
      outs       <= 2'd0;
      inning     <= INN_W'(1);
      half       <= 1'b0;
      game_over  <= 1'b0;
      sat        <= 1'b0;
    end else begin
      runs_valid <= 1'b0;
      case (state)
        IDLE: if (event_valid && event_ready) begin
          state <= APPLY;
          if (code_ok) begin
            runs_valid <= 1'b1;
            runs       <= mv_runs;
            score_away <= n_away;
            score_home <= n_home;
            sat        <= sat | clip;
            game_over  <= n_over;
            bases      <= third ? 3'b000 : mv_bases;
            outs       <= third ? 2'd0 : (is_out ? outs + 2'd1 : outs);
            half       <= third ? ~half : half;
            if (third && half && inning != MAX_INN) inning <= inning + INN_W'(1);
          end
        end
        APPLY: begin
          if (LOCKOUT == 0) state <= IDLE;
          else begin
            state    <= HOLD;
            hold_cnt <= 3'(LOCKOUT - 1);
          end
        end
        HOLD: begin
          if (hold_cnt == 3'd0) state <= IDLE;
          else hold_cnt <= hold_cnt - 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter SCORE_W, default 5, per-team score width in bits.
REQ-002 SHALL have parameter INN_W, default 4, inning counter width in bits.
REQ-003 SHALL have parameter INNINGS, default 9, regulation innings; legal range 1..2^INN_W-1.
REQ-004 SHALL have parameter LOCKOUT, default 1, idle cycles after each event during which no event is accepted; legal range 0..7.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port event_valid, input, 1, event_code is valid.
REQ-008 SHALL have port event_code, input, 3, event type: 1 single, 2 double, 3 triple, 4 home run, 5 walk, 6 out; 0 and 7 are invalid.
REQ-009 SHALL have port event_ready, output, 1, the block accepts an event this cycle.
REQ-010 SHALL have port bases, output, 3, runner occupancy: bit0 first, bit1 second, bit2 third.
REQ-011 SHALL have port runs, output, 3, runs scored by the last event (0..4).
REQ-012 SHALL have port runs_valid, output, 1, one-cycle strobe qualifying runs.
REQ-013 SHALL have ports score_away and score_home, output, SCORE_W each, team totals.
REQ-014 SHALL have port outs, output, 2, outs in the current half (0..2).
REQ-015 SHALL have port inning, output, INN_W, current inning, starting at 1.
REQ-016 SHALL have port half, output, 1: 0 = top (away batting), 1 = bottom (home batting).
REQ-017 SHALL have port game_over, output, 1, sticky; set when the game is decided.
REQ-018 SHALL have port sat, output, 1, sticky; set when any score saturated.

Function
REQ-019 SHALL accept an event on a cycle N where event_valid and event_ready are both 1; event_ready SHALL equal (state==IDLE) and not game_over.
REQ-020 SHALL use states IDLE -> APPLY (1 cycle) -> HOLD (LOCKOUT cycles) -> IDLE; with LOCKOUT=0, APPLY SHALL return directly to IDLE.
REQ-021 SHALL update bases, scores, outs, inning, half and game_over at cycle N+1, and SHALL pulse runs_valid at N+1 only.
REQ-022 event_ready SHALL be low from N+1 through N+LOCKOUT+1 inclusive, and high again at N+LOCKOUT+2.
REQ-023 Single SHALL advance every runner one base and place the batter on first; runs = bases[2].
REQ-024 Double SHALL advance every runner two bases and place the batter on second; runs = bases[2]+bases[1].
REQ-025 Triple SHALL score all runners and place the batter on third; runs = popcount(bases).
REQ-026 Home run SHALL score all runners plus the batter; runs = popcount(bases)+1; bases SHALL clear.
REQ-027 Walk SHALL place the batter on first and advance only forced runners; runs = 1 only when bases==3'b111.
REQ-028 Out SHALL increment outs and leave bases unchanged; runs = 0.
REQ-029 On the third out, outs and bases SHALL clear and half SHALL toggle; when half was 1, inning SHALL increment, saturating at 2^INN_W-1.
REQ-030 Invalid codes SHALL be accepted, SHALL cause no state change, SHALL NOT assert runs_valid, and SHALL still incur APPLY and HOLD.
REQ-031 Runs SHALL be added to the batting team's score, saturating at 2^SCORE_W-1; any clipping SHALL set sat.
REQ-032 game_over SHALL set on any of the following:
- third out of a top half with inning>=INNINGS and score_home>score_away;
- third out of a bottom half with inning>=INNINGS and the scores unequal;
- any event in a bottom half with inning>=INNINGS that makes score_home>score_away (walk-off).
REQ-033 On a tie at the end of inning INNINGS, play SHALL continue into extra innings.
REQ-034 Once game_over is set, all state SHALL freeze and event_valid SHALL be ignored.
REQ-035 runs SHALL hold its last value between strobes.

Reset
REQ-036 When reset is high at a clock edge, the block SHALL enter IDLE, and bases, runs, runs_valid, scores, outs, half, game_over and sat SHALL all become 0 and inning SHALL become 1.
REQ-037 Reset SHALL override any in-progress event, including an event in APPLY or HOLD; event_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-038 Bases 3'b100, single -> at N+1: runs=1, runs_valid=1, bases=3'b001, score_away=1; event_ready low for LOCKOUT+1 cycles.
REQ-039 Bases 3'b111, walk then home run -> runs=1 then runs=4; bases=3'b111 then 3'b000; score_away=5.
REQ-040 Bases 3'b110, double -> runs=2, bases=3'b010; bases 3'b010, walk -> runs=0, bases=3'b011.
REQ-041 Three outs in the top of inning 1 -> half=1, outs=0, bases=0; three more outs -> inning=2, half=0.
REQ-042 INNINGS=1, away 1, home 0, bottom 1 with bases 3'b100, double -> score_home=1 and play continues; next home run -> game_over=1, and further events are ignored.
REQ-043 SCORE_W=3, score_away=6, home run with bases 3'b001 -> score_away=7 and sat=1; assert reset during HOLD -> all outputs return to their reset values next cycle.
